// File: rtl/ps2_kbd_decoder.sv
// ps2_kbd_decoder
// Turns validated PS/2 scan-code set 2 bytes into ASCII characters and
// presents them to the LC-3 as a keyboard status/data register pair.
// Prefixes are tracked for make, break (F0) and extended (E0) codes.
// Shift and Caps Lock state are also tracked. Characters are queued in a
// small first-word-fall-through FIFO.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   cmd_rdy    one-cycle pulse, cmd holds a received byte
//   cmd        received scan-code byte
//   error      one-cycle pulse, current frame failed (parity/stop)
//   kbd_rd     one-cycle pulse, LC-3 read of KBDR, pops the FIFO head
//   kbsr_ready FIFO non-empty (KBSR[15])
//   kbdr       ASCII at the FIFO head, 0x00 when empty
//   overflow   sticky, a character was dropped because the FIFO was full
module ps2_kbd_decoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_rdy,
  input  logic [7:0] cmd,
  input  logic       error,
  input  logic       kbd_rd,
  output logic       kbsr_ready,
  output logic [7:0] kbdr,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  state_t state, next_state;

  logic lshift, rshift, caps;
  logic set_lshift, set_rshift, clr_lshift, clr_rshift, toggle_caps;
  logic push_req;

  logic       lut_valid;
  logic       lut_letter;
  logic [7:0] lut_norm;
  logic [7:0] lut_shift;
  logic       use_shifted;
  logic [7:0] ascii;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic full, empty, do_pop, do_push, ovf_event;

  // Scan-code set 2 lookup: unshifted and shifted character for each mapped
  // make code. Keys without a shifted form repeat the same character.
  always_comb begin
    lut_valid = 1'b1;
    lut_norm  = 8'h00;
    lut_shift = 8'h00;
    case (cmd)
      8'h1C: {lut_norm, lut_shift} = {8'h61, 8'h41};
      8'h32: {lut_norm, lut_shift} = {8'h62, 8'h42};
      8'h21: {lut_norm, lut_shift} = {8'h63, 8'h43};
      8'h23: {lut_norm, lut_shift} = {8'h64, 8'h44};
      8'h24: {lut_norm, lut_shift} = {8'h65, 8'h45};
      8'h2B: {lut_norm, lut_shift} = {8'h66, 8'h46};
      8'h34: {lut_norm, lut_shift} = {8'h67, 8'h47};
      8'h33: {lut_norm, lut_shift} = {8'h68, 8'h48};
      8'h43: {lut_norm, lut_shift} = {8'h69, 8'h49};
      8'h3B: {lut_norm, lut_shift} = {8'h6A, 8'h4A};
      8'h42: {lut_norm, lut_shift} = {8'h6B, 8'h4B};
      8'h4B: {lut_norm, lut_shift} = {8'h6C, 8'h4C};
      8'h3A: {lut_norm, lut_shift} = {8'h6D, 8'h4D};
      8'h31: {lut_norm, lut_shift} = {8'h6E, 8'h4E};
      8'h44: {lut_norm, lut_shift} = {8'h6F, 8'h4F};
      8'h4D: {lut_norm, lut_shift} = {8'h70, 8'h50};
      8'h15: {lut_norm, lut_shift} = {8'h71, 8'h51};
      8'h2D: {lut_norm, lut_shift} = {8'h72, 8'h52};
      8'h1B: {lut_norm, lut_shift} = {8'h73, 8'h53};
      8'h2C: {lut_norm, lut_shift} = {8'h74, 8'h54};
      8'h3C: {lut_norm, lut_shift} = {8'h75, 8'h55};
      8'h2A: {lut_norm, lut_shift} = {8'h76, 8'h56};
      8'h1D: {lut_norm, lut_shift} = {8'h77, 8'h57};
      8'h22: {lut_norm, lut_shift} = {8'h78, 8'h58};
      8'h35: {lut_norm, lut_shift} = {8'h79, 8'h59};
      8'h1A: {lut_norm, lut_shift} = {8'h7A, 8'h5A};
      8'h16: {lut_norm, lut_shift} = {8'h31, 8'h21};
      8'h1E: {lut_norm, lut_shift} = {8'h32, 8'h40};
      8'h26: {lut_norm, lut_shift} = {8'h33, 8'h23};
      8'h25: {lut_norm, lut_shift} = {8'h34, 8'h24};
      8'h2E: {lut_norm, lut_shift} = {8'h35, 8'h25};
      8'h36: {lut_norm, lut_shift} = {8'h36, 8'h5E};
      8'h3D: {lut_norm, lut_shift} = {8'h37, 8'h26};
      8'h3E: {lut_norm, lut_shift} = {8'h38, 8'h2A};
      8'h46: {lut_norm, lut_shift} = {8'h39, 8'h28};
      8'h45: {lut_norm, lut_shift} = {8'h30, 8'h29};
      8'h0E: {lut_norm, lut_shift} = {8'h60, 8'h7E};
      8'h4E: {lut_norm, lut_shift} = {8'h2D, 8'h5F};
      8'h55: {lut_norm, lut_shift} = {8'h3D, 8'h2B};
      8'h54: {lut_norm, lut_shift} = {8'h5B, 8'h7B};
      8'h5B: {lut_norm, lut_shift} = {8'h5D, 8'h7D};
      8'h5D: {lut_norm, lut_shift} = {8'h5C, 8'h7C};
      8'h4C: {lut_norm, lut_shift} = {8'h3B, 8'h3A};
      8'h52: {lut_norm, lut_shift} = {8'h27, 8'h22};
      8'h41: {lut_norm, lut_shift} = {8'h2C, 8'h3C};
      8'h49: {lut_norm, lut_shift} = {8'h2E, 8'h3E};
      8'h4A: {lut_norm, lut_shift} = {8'h2F, 8'h3F};
      8'h29: {lut_norm, lut_shift} = {8'h20, 8'h20};
      8'h5A: {lut_norm, lut_shift} = {8'h0D, 8'h0D};
      8'h66: {lut_norm, lut_shift} = {8'h08, 8'h08};
      8'h0D: {lut_norm, lut_shift} = {8'h09, 8'h09};
      8'h76: {lut_norm, lut_shift} = {8'h1B, 8'h1B};
      default: lut_valid = 1'b0;
    endcase
  end

  // Only letters have a lowercase unshifted form, so that range identifies
  // the keys where Caps Lock participates.
  always_comb begin
    lut_letter  = (lut_norm >= 8'h61) && (lut_norm <= 8'h7A);
    use_shifted = lut_letter ? ((lshift | rshift) ^ caps) : (lshift | rshift);
    ascii       = use_shifted ? lut_shift : lut_norm;
  end

  // Prefix state register; error abandons any partial sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      lshift <= 1'b0;
      rshift <= 1'b0;
      caps   <= 1'b0;
    end else begin
      state <= next_state;
      if (set_lshift) lshift <= 1'b1;
      else if (clr_lshift) lshift <= 1'b0;
      if (set_rshift) rshift <= 1'b1;
      else if (clr_rshift) rshift <= 1'b0;
      if (toggle_caps) caps <= ~caps;
    end
  end

  always_comb begin
    next_state  = state;
    set_lshift  = 1'b0;
    set_rshift  = 1'b0;
    clr_lshift  = 1'b0;
    clr_rshift  = 1'b0;
    toggle_caps = 1'b0;
    push_req    = 1'b0;
    if (error) begin
      next_state = IDLE;
    end else if (cmd_rdy) begin
      case (state)
        IDLE: begin
          if (cmd == 8'hF0)      next_state = BRK;
          else if (cmd == 8'hE0) next_state = EXT;
          else if (cmd == 8'h12) set_lshift = 1'b1;
          else if (cmd == 8'h59) set_rshift = 1'b1;
          else if (cmd == 8'h58) toggle_caps = 1'b1;
          else                   push_req = lut_valid;
        end
        BRK: begin
          clr_lshift = (cmd == 8'h12);
          clr_rshift = (cmd == 8'h59);
          next_state = IDLE;
        end
        EXT: begin
          next_state = (cmd == 8'hF0) ? EXT_BRK : IDLE;
        end
        EXT_BRK: begin
          next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // A pop on a full FIFO frees the slot the simultaneous push needs.
  always_comb begin
    full      = (count == FULL_COUNT);
    empty     = (count == '0);
    do_pop    = kbd_rd && !empty;
    do_push   = push_req && (!full || do_pop);
    ovf_event = push_req && full && !do_pop;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= ascii;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf_event)   overflow <= 1'b1;
      else if (kbd_rd) overflow <= 1'b0;
    end
  end

  assign kbsr_ready = !empty;
  assign kbdr       = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: doc/ps2_kbd_decoder.md
# ps2_kbd_decoder

Downstream consumer of `PS2_host`: takes each validated PS/2 scan-code byte (`cmd_rdy`/`cmd`) and the frame `error` pulse. It tracks make/break/extended prefixes, Shift and Caps Lock state, and translates make codes (scan-code set 2) to 8-bit ASCII. Results are buffered in a small FIFO and exposed as the LC-3 keyboard status/data pair (KBSR ready bit, KBDR data) with a read-acknowledge pop.

## Interface
- `FIFO_DEPTH`, 4, ASCII FIFO entries; power of two, ≥2.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `cmd_rdy`  in  1  one-cycle pulse; `cmd` holds a valid received byte.
- `cmd`  in  8  received scan-code byte from `PS2_host`.
- `error`  in  1  one-cycle pulse; the current frame failed (parity/stop).
- `kbd_rd`  in  1  one-cycle pulse; LC-3 read of KBDR, pops the FIFO head.
- `kbsr_ready`  out  1  FIFO non-empty (KBSR[15]).
- `kbdr`  out  8  ASCII at the FIFO head; 0x00 when empty.
- `overflow`  out  1  sticky; a character was dropped because the FIFO was full.

## Operation
- Decode FSM states: IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0). Advances only on `cmd_rdy`.
- IDLE:
  - F0 -> BRK.
  - E0 -> EXT.
  - 0x12/0x59 -> set lshift/rshift.
  - 0x58 -> toggle caps.
  - Other bytes -> lookup; a mapped code is pushed; stay IDLE.
- BRK: 0x12/0x59 clears lshift/rshift; any other byte is ignored; -> IDLE.
- EXT: F0 -> EXT_BRK; any other byte is discarded (no extended keys are mapped); -> IDLE.
- EXT_BRK: any byte -> IDLE, no effect.
- `shift` = lshift | rshift.
  - Letters a–z: uppercase when shift XOR caps.
  - Digits and punctuation: shifted variant when shift only.
- Map covers:
  - Letters, the top digit row, `` ` - = [ ] \ ; ' , . / `` plus their shifted forms.
  - Space 0x29->0x20, Enter 0x5A->0x0D, Backspace 0x66->0x08, Tab 0x0D->0x09, Esc 0x76->0x1B.
  - Unmapped codes push nothing.
- Examples: 0x1C -> 'a' 0x61 / 'A' 0x41; 0x16 -> '1' 0x31 / '!' 0x21; 0x4E -> '-' 0x2D / '_' 0x5F.
- `error`: FSM -> IDLE and the byte is discarded. Shift/caps state is retained. If `error` and `cmd_rdy` are high in the same cycle, `error` wins.
- FIFO is first-word-fall-through; `kbdr` always shows the head.
  - `kbd_rd` on empty: ignored.
  - Push on full without a simultaneous pop: new char is dropped and `overflow` is set.
  - Push and pop in the same cycle when full: both occur, no overflow.
  - Push and pop in the same cycle when empty: push occurs, pop is ignored.
- `overflow` is cleared by the next `kbd_rd`. If an overflow occurs in the same cycle as the clearing `kbd_rd`, `overflow` stays set.

## Timing
- Reset values: FSM=IDLE, lshift=rshift=caps=0, FIFO empty, `kbsr_ready`=0, `kbdr`=0x00, `overflow`=0.
- Lookup is combinational on `cmd` using the pre-edge shift/caps state. The push happens on the edge where `cmd_rdy`=1.
- `kbsr_ready`=1 and `kbdr` valid in the cycle following that edge: latency 1 cycle.
- Pop on the edge where `kbd_rd`=1. The next entry (or 0x00 and `kbsr_ready`=0) is visible the cycle after.
- Back-to-back `cmd_rdy` pulses on consecutive cycles must be handled; no input stall exists.
- Asynchronous reset mid-sequence (e.g. in BRK with Shift held) returns all state to reset values immediately.

## Test plan
- Reset, then `cmd`=0x1C pulse -> next cycle `kbsr_ready`=1, `kbdr`=0x61. `kbd_rd` pulse -> `kbsr_ready`=0, `kbdr`=0x00.
- Bytes 12, 1C, F0 1C, F0 12, 1C -> FIFO holds 0x41 then 0x61. The break codes push nothing; shift is cleared after F0 12.
- Byte 58, then 1C and 16 -> 0x41, 0x31 (caps does not affect digits). Then 12, 1C -> 0x61 (shift XOR caps).
- E0 75, E0 F0 75, then 29 -> only 0x20 is pushed; FSM back in IDLE after each extended sequence.
- Five mapped makes with no reads (depth 4) -> 4 entries, `overflow`=1. Fifth make coinciding with `kbd_rd` instead -> 4 entries, `overflow`=0.
- F0 then an `error` pulse, then 1C -> 0x61 pushed (prefix abandoned). `cmd_rdy` and `error` in the same cycle -> nothing pushed.
